// File: rtl/spread_monitor.sv
// spread_monitor
//   Samples the running min/max from the min/max tracker, derives the spread
//   (max - min, clamped at 0 when min > max) and drives a debounced,
//   hysteretic alarm. Also keeps the peak spread and a saturating count of
//   alarm entries.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   minIn       signed running minimum from the tracker
//   maxIn       signed running maximum from the tracker
//   sampleEn    qualifies minIn/maxIn on this edge
//   clear       synchronous clear of peakSpread / alarmCount
//   alarm       debounced alarm flag (registered)
//   spreadOut   spread of the last enabled sample (registered)
//   peakSpread  largest spread since reset or clear
//   alarmCount  number of alarm entries, saturating at 0xFFFF
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no alarm, no high samples pending
// PEND_ON  | no alarm yet, cnt consecutive high samples seen
// ALARM    | alarm asserted, no low samples pending
// PEND_OFF | alarm asserted, cnt consecutive low samples seen

module spread_monitor #(
  parameter logic [31:0] HIGH_TH = 32'd4,
  parameter logic [31:0] LOW_TH  = 32'd1,
  parameter int unsigned HOLD    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] minIn,
  input  logic signed [31:0] maxIn,
  input  logic               sampleEn,
  input  logic               clear,
  output logic               alarm,
  output logic        [31:0] spreadOut,
  output logic        [31:0] peakSpread,
  output logic        [15:0] alarmCount
);

  typedef enum logic [1:0] {IDLE, PEND_ON, ALARM, PEND_OFF} state_t;

  localparam logic [7:0] HOLD_C = 8'(HOLD);

  state_t      state;
  logic [7:0]  cnt;
  logic [32:0] diff;
  logic [31:0] spread;
  logic        hi;
  logic        lo;
  logic        cnt_done;
  logic        entry;

  // Sign-extend both operands to 33 bits; bit 32 of the result is the sign.
  assign diff     = {maxIn[31], maxIn} - {minIn[31], minIn};
  assign spread   = diff[32] ? 32'd0 : diff[31:0];
  assign hi       = (spread >= HIGH_TH);
  assign lo       = (spread <= LOW_TH);
  assign cnt_done = ((cnt + 8'd1) == HOLD_C);

  // Alarm entry from IDLE/PEND_ON only; a bounce back from PEND_OFF is not
  // a new entry.
  assign entry = sampleEn && hi &&
                 (((state == IDLE) && (HOLD_C == 8'd1)) ||
                  ((state == PEND_ON) && cnt_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      alarm      <= 1'b0;
      spreadOut  <= 32'd0;
      peakSpread <= 32'd0;
      alarmCount <= 16'd0;
    end else begin
      if (sampleEn) begin
        spreadOut <= spread;
        case (state)
          IDLE: begin
            if (hi) begin
              if (HOLD_C == 8'd1) begin
                state <= ALARM;
                alarm <= 1'b1;
              end else begin
                state <= PEND_ON;
                cnt   <= 8'd1;
              end
            end
          end
          PEND_ON: begin
            if (!hi) begin
              state <= IDLE;
              cnt   <= 8'd0;
            end else if (cnt_done) begin
              state <= ALARM;
              cnt   <= 8'd0;
              alarm <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ALARM: begin
            if (lo) begin
              if (HOLD_C == 8'd1) begin
                state <= IDLE;
                alarm <= 1'b0;
              end else begin
                state <= PEND_OFF;
                cnt   <= 8'd1;
              end
            end
          end
          PEND_OFF: begin
            if (!lo) begin
              state <= ALARM;
              cnt   <= 8'd0;
            end else if (cnt_done) begin
              state <= IDLE;
              cnt   <= 8'd0;
              alarm <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 8'd0;
            alarm <= 1'b0;
          end
        endcase
      end

      if (clear) begin
        peakSpread <= sampleEn ? spread : 32'd0;
        alarmCount <= entry ? 16'd1 : 16'd0;
      end else begin
        if (sampleEn && (spread > peakSpread))
          peakSpread <= spread;
        if (entry && (alarmCount != 16'hFFFF))
          alarmCount <= alarmCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spread_monitor.sv
// Directed bench for spread_monitor with default parameters. A behavioural
// model computes the expected outputs for each driven sample and pushes them
// onto a scoreboard queue; they are popped and compared after the edge.
module tb_spread_monitor;

  localparam logic [31:0] HIGH_TH = 32'd4;
  localparam logic [31:0] LOW_TH  = 32'd1;
  localparam int          HOLD    = 2;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] minIn = '0;
  logic [31:0] maxIn = '0;
  logic        sampleEn = 1'b0;
  logic        clear = 1'b0;
  logic        alarm;
  logic [31:0] spreadOut;
  logic [31:0] peakSpread;
  logic [15:0] alarmCount;

  spread_monitor #(.HIGH_TH(HIGH_TH), .LOW_TH(LOW_TH), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .minIn(minIn), .maxIn(maxIn),
    .sampleEn(sampleEn), .clear(clear), .alarm(alarm),
    .spreadOut(spreadOut), .peakSpread(peakSpread), .alarmCount(alarmCount)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct packed {
    logic        alarm;
    logic [31:0] spread;
    logic [31:0] peak;
    logic [15:0] count;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state
  logic        m_alarm;
  int          m_run;
  logic [31:0] m_spread;
  logic [31:0] m_peak;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_alarm = 1'b0; m_run = 0; m_spread = '0; m_peak = '0; m_cnt = '0;
    q.delete();
  endtask

  task automatic model_step(input logic [31:0] mn, input logic [31:0] mx,
                            input logic en, input logic clr);
    longint      d;
    logic [31:0] s;
    logic        entry;
    exp_t        e;
    d = longint'($signed(mx)) - longint'($signed(mn));
    s = (d < 0) ? 32'd0 : d[31:0];
    entry = 1'b0;
    if (en) begin
      m_spread = s;
      if (!m_alarm) begin
        m_run = (s >= HIGH_TH) ? m_run + 1 : 0;
        if (m_run == HOLD) begin m_alarm = 1'b1; m_run = 0; entry = 1'b1; end
      end else begin
        m_run = (s <= LOW_TH) ? m_run + 1 : 0;
        if (m_run == HOLD) begin m_alarm = 1'b0; m_run = 0; end
      end
    end
    if (clr) begin
      m_peak = en ? s : 32'd0;
      m_cnt  = entry ? 16'd1 : 16'd0;
    end else begin
      if (en && s > m_peak) m_peak = s;
      if (entry && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.alarm = m_alarm; e.spread = m_spread; e.peak = m_peak; e.count = m_cnt;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, ".alarm"},  {31'd0, alarm}, {31'd0, e.alarm});
    chk({tag, ".spread"}, spreadOut, e.spread);
    chk({tag, ".peak"},   peakSpread, e.peak);
    chk({tag, ".count"},  {16'd0, alarmCount}, {16'd0, e.count});
  endtask

  task automatic step(input logic [31:0] mn, input logic [31:0] mx,
                      input logic en, input logic clr, input string tag);
    @(negedge clk);
    minIn = mn; maxIn = mx; sampleEn = en; clear = clr;
    model_step(mn, mx, en, clr);
    @(posedge clk);
    #1;
    check_sb(tag);
    sampleEn = 1'b0; clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".alarm"},  {31'd0, alarm}, 32'd0);
    chk({tag, ".spread"}, spreadOut, 32'd0);
    chk({tag, ".peak"},   peakSpread, 32'd0);
    chk({tag, ".count"},  {16'd0, alarmCount}, 32'd0);
  endtask

  initial begin
    // 1. reset with clock stopped
    model_reset();
    rst = 1'b1;
    #20;
    check_zero("reset");
    rst = 1'b0;
    #2;
    clk_run = 1'b1;

    // 2. alarm entry: spread 5 for two edges
    step(32'hFFFF_FFFF, 32'd4, 1'b1, 1'b0, "entry1");
    chk("entry1.spread5", spreadOut, 32'd5);
    chk("entry1.noalarm", {31'd0, alarm}, 32'd0);
    step(32'hFFFF_FFFF, 32'd4, 1'b1, 1'b0, "entry2");
    chk("entry2.alarm", {31'd0, alarm}, 32'd1);
    chk("entry2.count", {16'd0, alarmCount}, 32'd1);
    chk("entry2.peak", peakSpread, 32'd5);

    // 3. release with bounce: spreads 1,3,1,1
    step(32'd1, 32'd2, 1'b1, 1'b0, "rel1");
    step(32'd1, 32'd4, 1'b1, 1'b0, "rel3");
    chk("rel3.held", {31'd0, alarm}, 32'd1);
    step(32'd1, 32'd2, 1'b1, 1'b0, "rel1b");
    chk("rel1b.held", {31'd0, alarm}, 32'd1);
    step(32'd1, 32'd2, 1'b1, 1'b0, "rel1c");
    chk("rel1c.fall", {31'd0, alarm}, 32'd0);
    chk("rel1c.count", {16'd0, alarmCount}, 32'd1);

    // 4. arithmetic edges
    step(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "neg");
    chk("neg.spread0", spreadOut, 32'd0);
    step(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "maxspread");
    chk("maxspread.spread", spreadOut, 32'hFFFF_FFFF);
    chk("maxspread.peak", peakSpread, 32'hFFFF_FFFF);
    step(32'd0, 32'd0, 1'b1, 1'b0, "back_idle");

    // 5. enable gaps then clear
    step(32'd0, 32'd5, 1'b1, 1'b0, "gap_hi1");
    for (int i = 0; i < 3; i++) step(32'd0, 32'd0, 1'b0, 1'b0, "gap_off");
    chk("gap.noalarm", {31'd0, alarm}, 32'd0);
    step(32'd0, 32'd5, 1'b1, 1'b0, "gap_hi2");
    chk("gap.alarm", {31'd0, alarm}, 32'd1);
    step(32'd0, 32'd0, 1'b0, 1'b1, "clear_off");
    chk("clear.peak", peakSpread, 32'd0);
    chk("clear.count", {16'd0, alarmCount}, 32'd0);
    chk("clear.alarm", {31'd0, alarm}, 32'd1);

    // clear coinciding with an alarm entry
    step(32'd0, 32'd0, 1'b1, 1'b0, "lo1");
    step(32'd0, 32'd0, 1'b1, 1'b0, "lo2");
    step(32'd0, 32'd5, 1'b1, 1'b0, "ce_hi1");
    step(32'd0, 32'd5, 1'b1, 1'b1, "ce_hi2");
    chk("clear_entry.count", {16'd0, alarmCount}, 32'd1);
    chk("clear_entry.peak", peakSpread, 32'd5);

    // 6. async reset in PEND_ON
    step(32'd0, 32'd0, 1'b1, 1'b0, "lo3");
    step(32'd0, 32'd0, 1'b1, 1'b0, "lo4");
    step(32'd0, 32'd6, 1'b1, 1'b0, "pend_on");
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    #1;
    rst = 1'b0;
    model_reset();
    step(32'd0, 32'd6, 1'b1, 1'b0, "post_rst1");
    chk("post_rst1.noalarm", {31'd0, alarm}, 32'd0);
    step(32'd0, 32'd6, 1'b1, 1'b0, "post_rst2");
    chk("post_rst2.alarm", {31'd0, alarm}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
